// File: rtl/i2c_axi_lite_fifo_if.sv
// AXI4-Lite register front end for an I2C master: TX/RX byte FIFOs, command handshake, sticky status and irq.
// Optional busy watchdog is compiled in with `define I2C_AXI_TIMEOUT_EN.
module i2c_axi_lite_fifo_if #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LEN_W        = 8,
  parameter logic [6:0]  DEV_ADDR_RST = 7'h50,
  parameter int unsigned TIMEOUT_CYC  = 1000000
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_areset,
  input  logic [31:0]      s_axi_awaddr,
  input  logic             s_axi_awvalid,
  output logic             s_axi_awready,
  input  logic [31:0]      s_axi_wdata,
  input  logic             s_axi_wvalid,
  output logic             s_axi_wready,
  output logic [1:0]       s_axi_bresp,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  input  logic [31:0]      s_axi_araddr,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  output logic [31:0]      s_axi_rdata,
  output logic [1:0]       s_axi_rresp,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [6:0]       cmd_dev,
  output logic             cmd_rw,
  output logic             cmd_random,
  output logic [7:0]       cmd_mem,
  output logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             i2c_busy,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  output logic             irq
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [4:0] A_CTRL = 5'd0, A_DEV = 5'd1, A_MEM = 5'd2, A_LEN = 5'd3,
                         A_TX = 5'd4, A_RX = 5'd5, A_STAT = 5'd6;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  // Valid/ready: a beat transfers on a rising clock edge where both are high; a source
  // holds valid and its payload stable until that edge, and never waits on ready.
  logic             awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [4:0]       awidx_q, awidx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rw_q, rw_d, random_q, random_d, irq_en_q, irq_en_d;
  logic [6:0]       dev_q, dev_d, cmd_dev_q, cmd_dev_d;
  logic [7:0]       mem_q, mem_d, cmd_mem_q, cmd_mem_d;
  logic [LEN_W-1:0] len_q, len_d, cmd_len_q, cmd_len_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_rw_q, cmd_rw_d, cmd_random_q, cmd_random_d;
  logic             done_q, done_d, nack_q, nack_d, ovf_q, ovf_d, timeout_q, timeout_d;
  logic [PW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
`ifdef I2C_AXI_TIMEOUT_EN
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic             done_ign_q, done_ign_d;
`endif

  logic        aw_fire, w_fire, ar_fire, wr_go, wr_err, rd_err, start_ok, start, busy_w;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_flush, rx_flush, ovf_set, done_set, nack_set, to_set;
  logic [3:0]  w1c;
  logic [4:0]  wr_idx;
  logic [31:0] wr_dat, status_w;
  logic        unused_bits;

  assign aw_fire  = s_axi_awvalid & awready_q;
  assign w_fire   = s_axi_wvalid & wready_q;
  assign ar_fire  = s_axi_arvalid & arready_q;
  assign wr_go    = (aw_held_q | aw_fire) & (w_held_q | w_fire);
  assign wr_idx   = aw_held_q ? awidx_q : s_axi_awaddr[6:2];
  assign wr_dat   = w_held_q ? wdata_q : s_axi_wdata;
  assign busy_w   = cmd_valid_q | i2c_busy;
  assign tx_full  = (tx_cnt_q == DEPTH_C);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH_C);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_pop   = ~tx_empty & tx_ready;
  assign rx_push  = rx_valid & ~rx_full;
  assign ovf_set  = rx_valid & rx_full;
  assign status_w = {8'(rx_cnt_q), 8'(tx_cnt_q), 7'b0, rx_empty, rx_full, tx_empty, tx_full,
                     timeout_q, ovf_q, nack_q, done_q, busy_w};

  // A read command needs room for the whole transfer, a write needs all its bytes queued.
  assign start_ok = ~busy_w && (len_q != '0) &&
                    (wr_dat[1] ? ((32'(FIFO_DEPTH) - 32'(rx_cnt_q)) >= 32'(len_q))
                               : (32'(tx_cnt_q) >= 32'(len_q)));

  always_comb begin
    aw_held_d = aw_held_q;  w_held_d = w_held_q;  awidx_d = awidx_q;  wdata_d = wdata_q;
    bvalid_d  = bvalid_q;   bresp_d  = bresp_q;
    rvalid_d  = rvalid_q;   rresp_d  = rresp_q;   rdata_d = rdata_q;
    rw_d = rw_q;  random_d = random_q;  irq_en_d = irq_en_q;
    dev_d = dev_q;  mem_d = mem_q;  len_d = len_q;
    cmd_valid_d = cmd_valid_q;  cmd_dev_d = cmd_dev_q;  cmd_rw_d = cmd_rw_q;
    cmd_random_d = cmd_random_q;  cmd_mem_d = cmd_mem_q;  cmd_len_d = cmd_len_q;
    tx_push = 1'b0;  rx_pop = 1'b0;  tx_flush = 1'b0;  rx_flush = 1'b0;
    start = 1'b0;  wr_err = 1'b0;  rd_err = 1'b0;  w1c = 4'b0;  to_set = 1'b0;
`ifdef I2C_AXI_TIMEOUT_EN
    to_cnt_d = to_cnt_q;  done_ign_d = done_ign_q;
    done_set = i2c_done & ~done_ign_q;
`else
    done_set = i2c_done;
`endif
    nack_set = done_set & i2c_nack;

    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_idx)
        A_CTRL: begin
          rw_d     = wr_dat[1];
          random_d = wr_dat[2];
          tx_flush = wr_dat[3];
          rx_flush = wr_dat[4];
          irq_en_d = wr_dat[8];
          if (wr_dat[0]) begin
            if (start_ok) start = 1'b1;
            else          wr_err = 1'b1;
          end
        end
        A_DEV:  dev_d = wr_dat[6:0];
        A_MEM:  mem_d = wr_dat[7:0];
        A_LEN:  len_d = wr_dat[LEN_W-1:0];
        A_TX: begin
          if (tx_full) wr_err = 1'b1;
          else         tx_push = 1'b1;
        end
        A_RX:   ;
        A_STAT: w1c = wr_dat[4:1];
        default: wr_err = 1'b1;
      endcase
      bresp_d = wr_err ? SLVERR : OKAY;
    end else begin
      if (aw_fire) begin aw_held_d = 1'b1; awidx_d = s_axi_awaddr[6:2]; end
      if (w_fire)  begin w_held_d = 1'b1;  wdata_d = s_axi_wdata; end
      if (bvalid_q & s_axi_bready) begin bvalid_d = 1'b0; bresp_d = OKAY; end
    end

    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      case (s_axi_araddr[6:2])
        A_CTRL: rdata_d = {23'b0, irq_en_q, 5'b0, random_q, rw_q, 1'b0};
        A_DEV:  rdata_d = {25'b0, dev_q};
        A_MEM:  rdata_d = {24'b0, mem_q};
        A_LEN:  rdata_d = 32'(len_q);
        A_TX:   ;
        A_RX: begin
          if (rx_empty) rd_err = 1'b1;
          else begin rx_pop = 1'b1; rdata_d = {24'b0, rx_mem[rx_rp_q]}; end
        end
        A_STAT: rdata_d = status_w;
        default: rd_err = 1'b1;
      endcase
      rresp_d = rd_err ? SLVERR : OKAY;
    end else if (rvalid_q & s_axi_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = OKAY;
    end

    if (cmd_valid_q & cmd_ready) cmd_valid_d = 1'b0;
    if (start) begin
      cmd_valid_d  = 1'b1;
      cmd_dev_d    = dev_q;
      cmd_rw_d     = wr_dat[1];
      cmd_random_d = wr_dat[2];
      cmd_mem_d    = mem_q;
      cmd_len_d    = len_q;
    end

`ifdef I2C_AXI_TIMEOUT_EN
    to_cnt_d = busy_w ? to_cnt_q + 32'd1 : 32'd0;
    if (start) done_ign_d = 1'b0;
    // A stuck transfer is abandoned: the late done pulse must not look like success.
    if (busy_w && (to_cnt_q + 32'd1 == 32'(TIMEOUT_CYC))) begin
      to_set      = 1'b1;
      cmd_valid_d = 1'b0;
      tx_flush    = 1'b1;
      rx_flush    = 1'b1;
      done_ign_d  = 1'b1;
    end
`endif

    done_d    = (done_q & ~w1c[0]) | done_set;
    nack_d    = (nack_q & ~w1c[1]) | nack_set;
    ovf_d     = (ovf_q & ~w1c[2]) | ovf_set;
    timeout_d = (timeout_q & ~w1c[3]) | to_set;

    tx_wp_d = tx_wp_q;  tx_rp_d = tx_rp_q;  tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wp_d = '0;  tx_rp_d = '0;  tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + PW'(1);
      if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
      else if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    end

    rx_wp_d = rx_wp_q;  rx_rp_d = rx_rp_q;  rx_cnt_d = rx_cnt_q;
    if (rx_flush) begin
      rx_wp_d = '0;  rx_rp_d = '0;  rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wp_d = rx_wp_q + PW'(1);
      if (rx_pop)  rx_rp_d = rx_rp_q + PW'(1);
      if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
      else if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end

    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      awready_q <= 1'b0;  wready_q <= 1'b0;  arready_q <= 1'b0;
      aw_held_q <= 1'b0;  w_held_q <= 1'b0;  awidx_q <= '0;  wdata_q <= '0;
      bvalid_q  <= 1'b0;  bresp_q  <= OKAY;  rvalid_q <= 1'b0;  rresp_q <= OKAY;  rdata_q <= '0;
      rw_q <= 1'b0;  random_q <= 1'b0;  irq_en_q <= 1'b0;
      dev_q <= DEV_ADDR_RST;  mem_q <= '0;  len_q <= '0;
      cmd_valid_q <= 1'b0;  cmd_dev_q <= '0;  cmd_rw_q <= 1'b0;
      cmd_random_q <= 1'b0;  cmd_mem_q <= '0;  cmd_len_q <= '0;
      done_q <= 1'b0;  nack_q <= 1'b0;  ovf_q <= 1'b0;  timeout_q <= 1'b0;
      tx_wp_q <= '0;  tx_rp_q <= '0;  tx_cnt_q <= '0;
      rx_wp_q <= '0;  rx_rp_q <= '0;  rx_cnt_q <= '0;
`ifdef I2C_AXI_TIMEOUT_EN
      to_cnt_q <= '0;  done_ign_q <= 1'b0;
`endif
    end else begin
      awready_q <= awready_d;  wready_q <= wready_d;  arready_q <= arready_d;
      aw_held_q <= aw_held_d;  w_held_q <= w_held_d;  awidx_q <= awidx_d;  wdata_q <= wdata_d;
      bvalid_q  <= bvalid_d;   bresp_q  <= bresp_d;
      rvalid_q  <= rvalid_d;   rresp_q  <= rresp_d;   rdata_q <= rdata_d;
      rw_q <= rw_d;  random_q <= random_d;  irq_en_q <= irq_en_d;
      dev_q <= dev_d;  mem_q <= mem_d;  len_q <= len_d;
      cmd_valid_q <= cmd_valid_d;  cmd_dev_q <= cmd_dev_d;  cmd_rw_q <= cmd_rw_d;
      cmd_random_q <= cmd_random_d;  cmd_mem_q <= cmd_mem_d;  cmd_len_q <= cmd_len_d;
      done_q <= done_d;  nack_q <= nack_d;  ovf_q <= ovf_d;  timeout_q <= timeout_d;
      tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;  rx_cnt_q <= rx_cnt_d;
`ifdef I2C_AXI_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;  done_ign_q <= done_ign_d;
`endif
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and counts.
  always_ff @(posedge s_axi_aclk) begin
    if (tx_push) tx_mem[tx_wp_q] <= wr_dat[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_dev       = cmd_dev_q;
  assign cmd_rw        = cmd_rw_q;
  assign cmd_random    = cmd_random_q;
  assign cmd_mem       = cmd_mem_q;
  assign cmd_len       = cmd_len_q;
  assign tx_valid      = ~tx_empty;
  assign tx_data       = tx_mem[tx_rp_q];
  assign irq           = irq_en_q & (done_q | nack_q | ovf_q | timeout_q);

`ifdef I2C_AXI_TIMEOUT_EN
  assign unused_bits = ^{s_axi_awaddr[31:7], s_axi_awaddr[1:0], s_axi_araddr[31:7],
                         s_axi_araddr[1:0], wr_dat};
`else
  assign unused_bits = ^{s_axi_awaddr[31:7], s_axi_awaddr[1:0], s_axi_araddr[31:7],
                         s_axi_araddr[1:0], wr_dat, 32'(TIMEOUT_CYC)};
`endif
endmodule

// File: tb/tb_i2c_axi_lite_fifo_if.sv
// Directed bench for i2c_axi_lite_fifo_if: register/FIFO/command behaviour and AXI channel ordering.
module tb_i2c_axi_lite_fifo_if;
  logic        s_axi_aclk = 1'b0, s_axi_areset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic        cmd_valid, cmd_ready, cmd_rw, cmd_random;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_mem, cmd_len, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, i2c_busy, i2c_done, i2c_nack, irq;

  int n_cmp = 0, n_err = 0;
  logic [7:0] pw_bytes [4] = '{8'hA5, 8'h5A, 8'h11, 8'h22};

  localparam logic [31:0] R_CTRL = 32'h00, R_DEV = 32'h04, R_MEM = 32'h08, R_LEN = 32'h0C,
                          R_TX = 32'h10, R_RX = 32'h14, R_STAT = 32'h18;

  i2c_axi_lite_fifo_if dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_rw(cmd_rw),
    .cmd_random(cmd_random), .cmd_mem(cmd_mem), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .irq(irq)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit aw_pend = 1'b1, w_pend = 1'b1, aw_go, w_go;
    int n = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while ((aw_pend || w_pend) && n < 40) begin
      aw_go = aw_pend & s_axi_awready;
      w_go  = w_pend & s_axi_wready;
      @(negedge s_axi_aclk);
      if (aw_go) begin aw_pend = 1'b0; s_axi_awvalid = 1'b0; end
      if (w_go)  begin w_pend = 1'b0;  s_axi_wvalid = 1'b0; end
      n++;
    end
    while (!s_axi_bvalid && n < 40) begin @(negedge s_axi_aclk); n++; end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (n >= 40) bound_fail("wr_handshake");
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit go;
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (s_axi_arvalid && n < 40) begin
      go = s_axi_arready;
      @(negedge s_axi_aclk);
      if (go) s_axi_arvalid = 1'b0;
      n++;
    end
    while (!s_axi_rvalid && n < 40) begin @(negedge s_axi_aclk); n++; end
    s_axi_arvalid = 1'b0;
    if (n >= 40) bound_fail("rd_handshake");
    d = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_rready = 1'b0;
  endtask

  task automatic pulse_done(input logic nack);
    i2c_done = 1'b1; i2c_nack = nack;
    @(negedge s_axi_aclk);
    i2c_done = 1'b0; i2c_nack = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    s_axi_areset = 1'b1;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_araddr = '0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    cmd_ready = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;
    i2c_busy = 0; i2c_done = 0; i2c_nack = 0;
    repeat (3) @(negedge s_axi_aclk);
    check("rst_awready", 32'(s_axi_awready), 0);
    check("rst_arready", 32'(s_axi_arready), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    s_axi_areset = 1'b0;
    @(negedge s_axi_aclk);
    axi_read(R_STAT, rd, rs);  check("rst_status", rd, 32'h140);
    axi_read(R_DEV, rd, rs);   check("rst_dev", rd, 32'h50);

    // Page write
    for (int i = 0; i < 4; i++) begin
      axi_write(R_TX, 32'(pw_bytes[i]), rs); check("pw_push_resp", 32'(rs), 0);
    end
    axi_write(R_LEN, 32'd4, rs);
    axi_write(R_MEM, 32'h10, rs);
    axi_write(R_CTRL, 32'h101, rs);  check("pw_start_resp", 32'(rs), 0);
    check("pw_cmd_valid", 32'(cmd_valid), 1);
    check("pw_cmd_dev", 32'(cmd_dev), 32'h50);
    check("pw_cmd_rw", 32'(cmd_rw), 0);
    check("pw_cmd_len", 32'(cmd_len), 4);
    check("pw_cmd_mem", 32'(cmd_mem), 32'h10);
    axi_read(R_STAT, rd, rs);  check("pw_status_busy", rd, 32'h0004_0101);
    check("pw_irq_idle", 32'(irq), 0);
    cmd_ready = 1'b1; @(negedge s_axi_aclk); cmd_ready = 1'b0;
    check("pw_cmd_taken", 32'(cmd_valid), 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pw_tx_valid", 32'(tx_valid), 1);
      check("pw_tx_data", 32'(tx_data), 32'(pw_bytes[i]));
      @(negedge s_axi_aclk);
    end
    tx_ready = 1'b0;
    check("pw_tx_drained", 32'(tx_valid), 0);
    pulse_done(1'b0);
    check("pw_irq", 32'(irq), 1);
    axi_read(R_STAT, rd, rs);  check("pw_status_done", rd, 32'h142);
    axi_write(R_STAT, 32'h2, rs);
    check("pw_irq_cleared", 32'(irq), 0);

    // Sequential read
    axi_write(R_LEN, 32'd3, rs);
    axi_write(R_CTRL, 32'h7, rs);  check("sr_start_resp", 32'(rs), 0);
    check("sr_cmd_rw", 32'(cmd_rw), 1);
    check("sr_cmd_random", 32'(cmd_random), 1);
    check("sr_cmd_len", 32'(cmd_len), 3);
    cmd_ready = 1'b1; @(negedge s_axi_aclk); cmd_ready = 1'b0;
    rx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin rx_data = 8'(i); @(negedge s_axi_aclk); end
    rx_valid = 1'b0;
    pulse_done(1'b0);
    check("sr_irq_disabled", 32'(irq), 0);
    for (int i = 1; i <= 3; i++) begin
      axi_read(R_RX, rd, rs);
      check("sr_rx_data", rd, 32'(i));
      check("sr_rx_resp", 32'(rs), 0);
    end
    axi_read(R_RX, rd, rs);
    check("sr_empty_data", rd, 0);
    check("sr_empty_resp", 32'(rs), 2);
    axi_write(R_STAT, 32'h2, rs);

    // START rejection
    axi_write(R_LEN, 32'd0, rs);
    axi_write(R_CTRL, 32'h1, rs);  check("rej_len0_resp", 32'(rs), 2);
    check("rej_len0_cmd", 32'(cmd_valid), 0);
    axi_write(R_TX, 32'h77, rs);
    axi_write(R_TX, 32'h88, rs);
    axi_write(R_LEN, 32'd5, rs);
    axi_write(R_CTRL, 32'h1, rs);  check("rej_short_resp", 32'(rs), 2);
    check("rej_short_cmd", 32'(cmd_valid), 0);
    axi_write(R_LEN, 32'd2, rs);
    i2c_busy = 1'b1;
    axi_write(R_CTRL, 32'h5, rs);  check("rej_busy_resp", 32'(rs), 2);
    check("rej_busy_cmd", 32'(cmd_valid), 0);
    axi_read(R_CTRL, rd, rs);      check("rej_ctrl_kept", rd, 32'h4);
    axi_read(R_STAT, rd, rs);      check("rej_status", rd, 32'h0002_0101);
    i2c_busy = 1'b0;
    axi_write(R_CTRL, 32'h8, rs);  check("tx_flush_resp", 32'(rs), 0);
    axi_read(R_STAT, rd, rs);      check("tx_flush_status", rd, 32'h140);

    // FIFO limits
    for (int i = 0; i < 16; i++) begin
      axi_write(R_TX, 32'(i), rs); check("fill_tx_resp", 32'(rs), 0);
    end
    axi_write(R_TX, 32'hEE, rs);   check("tx_overfill_resp", 32'(rs), 2);
    axi_read(R_STAT, rd, rs);      check("tx_full_status", rd, 32'h0010_0120);
    check("tx_head", 32'(tx_data), 0);
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin rx_data = 8'(8'h30 + i); @(negedge s_axi_aclk); end
    rx_valid = 1'b0;
    axi_read(R_STAT, rd, rs);      check("rx_ovf_status", rd, 32'h1010_00A8);
    axi_write(R_STAT, 32'h8, rs);
    axi_read(R_STAT, rd, rs);      check("rx_ovf_cleared", rd, 32'h1010_00A0);
    axi_read(R_RX, rd, rs);        check("rx_head", rd, 32'h30);
    axi_read(R_STAT, rd, rs);      check("rx_level_15", rd, 32'h0F10_0020);
    axi_write(R_CTRL, 32'h18, rs);
    axi_read(R_STAT, rd, rs);      check("both_flushed", rd, 32'h140);

    // W three cycles ahead of AW
    s_axi_wdata = 32'h33; s_axi_wvalid = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_wvalid = 1'b0;
    check("ord_b_early1", 32'(s_axi_bvalid), 0);
    @(negedge s_axi_aclk);
    check("ord_b_early2", 32'(s_axi_bvalid), 0);
    @(negedge s_axi_aclk);
    check("ord_b_early3", 32'(s_axi_bvalid), 0);
    s_axi_awaddr = R_MEM; s_axi_awvalid = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0;
    check("ord_bvalid", 32'(s_axi_bvalid), 1);
    check("ord_bresp", 32'(s_axi_bresp), 0);
    s_axi_bready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_bready = 1'b0;
    check("ord_single_b", 32'(s_axi_bvalid), 0);
    axi_read(R_MEM, rd, rs);       check("ord_mem", rd, 32'h33);

    // AW+W and AR in the same cycle
    check("same_awready", 32'(s_axi_awready), 1);
    s_axi_awaddr = R_LEN; s_axi_wdata = 32'd7; s_axi_araddr = R_STAT;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("same_bvalid", 32'(s_axi_bvalid), 1);
    check("same_rvalid", 32'(s_axi_rvalid), 1);
    check("same_rdata", s_axi_rdata, 32'h140);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(R_LEN, rd, rs);       check("same_len", rd, 32'd7);

    // Bad offsets
    axi_read(32'h1C, rd, rs);
    check("bad_rd_data", rd, 0);
    check("bad_rd_resp", 32'(rs), 2);
    axi_write(32'h20, 32'h1, rs);  check("bad_wr_resp", 32'(rs), 2);

    // NACK and set-beats-clear
    pulse_done(1'b1);
    axi_read(R_STAT, rd, rs);      check("nack_status", rd, 32'h146);
    s_axi_awaddr = R_STAT; s_axi_wdata = 32'h6;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; i2c_done = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; i2c_done = 1'b0;
    check("w1c_race_bvalid", 32'(s_axi_bvalid), 1);
    s_axi_bready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_bready = 1'b0;
    axi_read(R_STAT, rd, rs);      check("set_wins", rd, 32'h142);
    axi_write(R_STAT, 32'h1E, rs);
    axi_read(R_STAT, rd, rs);      check("all_clear", rd, 32'h140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
